// File: rtl/exe_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : exe_mul_unit
//  Description : Iterative shift-add 32x32 multiplier for the EXE stage.
//                Operands are converted to magnitudes and the result sign is
//                fixed up after the last step. The unit stalls the front end
//                while it iterates.
//  Revision    : 1.0 - initial release
// ============================================================================
module exe_mul_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall_req,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int c_CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_CNT_W-1:0]   r_count;
  logic [WIDTH-1:0]     r_mcand;
  logic [2*WIDTH-1:0]   r_prod;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;

  logic [WIDTH-1:0]     w_mag_a;
  logic [WIDTH-1:0]     w_mag_b;
  logic [WIDTH:0]       w_sum;
  logic [2*WIDTH-1:0]   w_result;
  logic                 w_last;
  logic                 w_accept;

  // The most negative value maps onto itself, which is the correct unsigned magnitude.
  assign w_mag_a  = (is_signed && a[WIDTH-1]) ? (~a + WIDTH'(1)) : a;
  assign w_mag_b  = (is_signed && b[WIDTH-1]) ? (~b + WIDTH'(1)) : b;
  assign w_sum    = r_prod[0] ? ({1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, r_mcand})
                              : {1'b0, r_prod[2*WIDTH-1:WIDTH]};
  assign w_result = r_neg ? (~r_prod + (2*WIDTH)'(1)) : r_prod;
  assign w_last   = (r_count == c_CNT_W'(WIDTH - 1));
  assign w_accept = (r_state == S_IDLE) && start && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_mcand <= '0;
      r_prod  <= '0;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_mcand <= w_mag_a;
        r_prod  <= {{WIDTH{1'b0}}, w_mag_b};
        r_neg   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
        r_count <= '0;
      end else if ((r_state == S_RUN) && !flush) begin
        r_prod  <= {w_sum, r_prod[WIDTH-1:1]};
        r_count <= r_count + c_CNT_W'(1);
      end
      if (done) begin
        {r_hi, r_lo} <= w_result;
      end
    end
  end

  // During DONE the fresh product is shown directly so it is valid alongside done.
  assign done      = (r_state == S_DONE) && !flush;
  assign busy      = (r_state == S_RUN) || (r_state == S_DONE);
  assign stall_req = w_accept || (r_state == S_RUN);
  assign hi        = done ? w_result[2*WIDTH-1:WIDTH] : r_hi;
  assign lo        = done ? w_result[WIDTH-1:0]       : r_lo;

endmodule
`default_nettype wire

// File: tb/tb_exe_mul_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exe_mul_unit
//  Description : Self-checking bench for exe_mul_unit: per-cycle comparison
//                against a cycle-count/arithmetic model plus literal results.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_exe_mul_unit;

  localparam int WIDTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic        flush;
  logic [31:0] a;
  logic [31:0] b;
  logic        stall_req;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  exe_mul_unit #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .stall_req (stall_req),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  function automatic logic [63:0] ref_product(input logic [31:0] x, input logic [31:0] y,
                                              input logic s);
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    if (s) return sx * sy;
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: m_t is the cycle index within an operation (0 = idle, 1..32 run, 33 result).
  int          m_t = 0;
  logic [63:0] m_prod = '0;
  logic [63:0] m_held = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_t    = 0;
      m_held = '0;
    end else if (flush) begin
      m_t = 0;
    end else if (m_t == 0) begin
      if (start) begin
        m_t    = 1;
        m_prod = ref_product(a, b, is_signed);
      end
    end else if (m_t == WIDTH + 1) begin
      m_held = m_prod;
      m_t    = 0;
    end else begin
      m_t++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_done;
      logic        e_stall;
      logic [63:0] e_prod;
      e_done  = (m_t == WIDTH + 1) && !flush;
      e_stall = ((m_t == 0) && start && !flush) || ((m_t >= 1) && (m_t <= WIDTH));
      e_prod  = e_done ? m_prod : m_held;
      check("model_done",  {63'b0, done},      {63'b0, e_done});
      check("model_busy",  {63'b0, busy},      {63'b0, (m_t != 0)});
      check("model_stall", {63'b0, stall_req}, {63'b0, e_stall});
      check("model_hilo",  {hi, lo},           e_prod);
    end
  end

  task automatic start_op(input logic [31:0] ta, input logic [31:0] tb, input logic ts);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb; is_signed = ts;
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", {63'b0, busy}, 64'd1);
  endtask

  // Returns at the negedge of the done cycle, which must be cycle 33.
  task automatic wait_done(input logic [31:0] ehi, input logic [31:0] elo);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        cyc = i + 1;
        break;
      end
    end
    if (cyc == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: no done within 40 cycles, expected cycle 33");
    end else begin
      check("done_cycle", 64'(cyc), 64'd33);
      check("result", {hi, lo}, {ehi, elo});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_outputs", {59'b0, done, busy, stall_req, 2'b0}, 64'd0);
    check("rst_hilo", {hi, lo}, 64'd0);

    start_op(32'd3, 32'd5, 1'b0);
    wait_done(32'h0, 32'd15);
    start_op(32'hFFFF_FFF9, 32'd6, 1'b1);
    wait_done(32'hFFFF_FFFF, 32'hFFFF_FFD6);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    wait_done(32'hFFFF_FFFE, 32'h0000_0001);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(32'h0, 32'h1);
    start_op(32'h8000_0000, 32'h8000_0000, 1'b1);
    wait_done(32'h4000_0000, 32'h0);

    // Flush in cycle 10 of a 9x9 after a completed 3x5.
    start_op(32'd3, 32'd5, 1'b0);
    wait_done(32'h0, 32'd15);
    start_op(32'd9, 32'd9, 1'b0);
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_stall", {63'b0, stall_req}, 64'd0);
    check("flush_busy",  {63'b0, busy}, 64'd0);
    check("flush_hilo",  {hi, lo}, 64'd15);
    start_op(32'd2, 32'd4, 1'b0);
    wait_done(32'h0, 32'd8);

    // Reset in cycle 20.
    start_op(32'd9, 32'd9, 1'b0);
    repeat (19) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_outputs", {59'b0, done, busy, stall_req, 2'b0}, 64'd0);
    check("midrst_hilo", {hi, lo}, 64'd0);

    // Start held from DONE into the following IDLE cycle.
    start_op(32'd1000, 32'd1000, 1'b0);
    wait_done(32'h0, 32'h000F_4240);
    #1;
    start = 1'b1; a = 32'hFFFF_FFFE; b = 32'd3; is_signed = 1'b1;
    @(posedge clk); #1;
    check("b2b_idle_busy",  {63'b0, busy}, 64'd0);
    check("b2b_idle_stall", {63'b0, stall_req}, 64'd1);
    check("b2b_held_hilo",  {hi, lo}, 64'h0000_0000_000F_4240);
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept", {63'b0, busy}, 64'd1);
    wait_done(32'hFFFF_FFFF, 32'hFFFF_FFFA);

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
